// File: rtl/tx_ctrl_sequencer.sv
// C-PHY transmit lane control sequencer: walks the LP line through Stop / HS-Request /
// Bridge / LP-Request, hands the lane to the HS serializer and holds HS trail on exit.
module tx_ctrl_sequencer #(
    parameter int unsigned T_HS_RQST  = 3,
    parameter int unsigned T_BRIDGE   = 5,
    parameter int unsigned T_TRAIL    = 4,
    parameter int unsigned T_LP_RQST  = 3,
    parameter int unsigned T_STOP_MIN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       HsReq,
    input  logic       LpReq,
    output logic       LpA,
    output logic       LpB,
    output logic       LpC,
    output logic       LpOe,
    output logic       HsEn,
    output logic       TxReadyHS,
    output logic       LpDone,
    output logic [1:0] CtrlCode
);

    localparam logic [7:0] LD_HS_RQST  = 8'(T_HS_RQST - 1);
    localparam logic [7:0] LD_BRIDGE   = 8'(T_BRIDGE - 1);
    localparam logic [7:0] LD_TRAIL    = 8'(T_TRAIL - 1);
    localparam logic [7:0] LD_LP_RQST  = 8'(T_LP_RQST - 1);
    localparam logic [7:0] LD_STOP_MIN = 8'(T_STOP_MIN - 1);

    localparam logic [2:0] ABC_STOP    = 3'b111;
    localparam logic [2:0] ABC_HS_RQST = 3'b001;
    localparam logic [2:0] ABC_BRIDGE  = 3'b000;
    localparam logic [2:0] ABC_LP_RQST = 3'b100;

    localparam logic [1:0] CODE_STOP    = 2'b00;
    localparam logic [1:0] CODE_HS_RQST = 2'b01;
    localparam logic [1:0] CODE_BRIDGE  = 2'b10;
    localparam logic [1:0] CODE_LP_RQST = 2'b11;

    typedef enum logic [2:0] {
        ST_STOP,
        ST_HS_RQST,
        ST_BRIDGE,
        ST_HS_ACTIVE,
        ST_HS_TRAIL,
        ST_LP_RQST
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic [7:0] w_cnt_dec;
    logic       w_cnt_zero;
    logic       w_lp_done_next;

    logic [2:0] r_abc;
    logic       r_lp_oe;
    logic       r_hs_en;
    logic       r_tx_ready;
    logic       r_lp_done;
    logic [1:0] r_ctrl_code;

    assign w_cnt_zero = (r_cnt == 8'd0);
    assign w_cnt_dec  = w_cnt_zero ? 8'd0 : (r_cnt - 8'd1);

    // Dropped requests win over timer expiry so an abort never leaks into the next state.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = w_cnt_dec;
        w_lp_done_next = 1'b0;
        case (r_state)
            ST_STOP: begin
                if (w_cnt_zero && HsReq) begin
                    w_state_next = ST_HS_RQST;
                    w_cnt_next   = LD_HS_RQST;
                end else if (w_cnt_zero && LpReq) begin
                    w_state_next = ST_LP_RQST;
                    w_cnt_next   = LD_LP_RQST;
                end
            end
            ST_HS_RQST: begin
                if (!HsReq) begin
                    w_state_next = ST_STOP;
                    w_cnt_next   = LD_STOP_MIN;
                end else if (w_cnt_zero) begin
                    w_state_next = ST_BRIDGE;
                    w_cnt_next   = LD_BRIDGE;
                end
            end
            ST_BRIDGE: begin
                if (!HsReq) begin
                    w_state_next = ST_STOP;
                    w_cnt_next   = LD_STOP_MIN;
                end else if (w_cnt_zero) begin
                    w_state_next = ST_HS_ACTIVE;
                    w_cnt_next   = 8'd0;
                end
            end
            ST_HS_ACTIVE: begin
                if (!HsReq) begin
                    w_state_next = ST_HS_TRAIL;
                    w_cnt_next   = LD_TRAIL;
                end
            end
            ST_HS_TRAIL: begin
                if (w_cnt_zero) begin
                    w_state_next = ST_STOP;
                    w_cnt_next   = LD_STOP_MIN;
                end
            end
            ST_LP_RQST: begin
                if (!LpReq) begin
                    w_state_next = ST_STOP;
                    w_cnt_next   = LD_STOP_MIN;
                end else if (w_cnt_zero) begin
                    w_state_next   = ST_STOP;
                    w_cnt_next     = LD_STOP_MIN;
                    w_lp_done_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_STOP;
                w_cnt_next   = LD_STOP_MIN;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_STOP;
            r_cnt       <= 8'd0;
            r_abc       <= ABC_STOP;
            r_lp_oe     <= 1'b1;
            r_hs_en     <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_lp_done   <= 1'b0;
            r_ctrl_code <= CODE_STOP;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_lp_done <= w_lp_done_next;
            case (w_state_next)
                ST_HS_RQST: begin
                    r_abc       <= ABC_HS_RQST;
                    r_lp_oe     <= 1'b1;
                    r_hs_en     <= 1'b0;
                    r_tx_ready  <= 1'b0;
                    r_ctrl_code <= CODE_HS_RQST;
                end
                ST_BRIDGE: begin
                    r_abc       <= ABC_BRIDGE;
                    r_lp_oe     <= 1'b1;
                    r_hs_en     <= 1'b0;
                    r_tx_ready  <= 1'b0;
                    r_ctrl_code <= CODE_BRIDGE;
                end
                ST_HS_ACTIVE: begin
                    r_abc       <= ABC_BRIDGE;
                    r_lp_oe     <= 1'b0;
                    r_hs_en     <= 1'b1;
                    r_tx_ready  <= 1'b1;
                    r_ctrl_code <= CODE_STOP;
                end
                ST_HS_TRAIL: begin
                    r_abc       <= ABC_BRIDGE;
                    r_lp_oe     <= 1'b0;
                    r_hs_en     <= 1'b1;
                    r_tx_ready  <= 1'b0;
                    r_ctrl_code <= CODE_STOP;
                end
                ST_LP_RQST: begin
                    r_abc       <= ABC_LP_RQST;
                    r_lp_oe     <= 1'b1;
                    r_hs_en     <= 1'b0;
                    r_tx_ready  <= 1'b0;
                    r_ctrl_code <= CODE_LP_RQST;
                end
                default: begin
                    r_abc       <= ABC_STOP;
                    r_lp_oe     <= 1'b1;
                    r_hs_en     <= 1'b0;
                    r_tx_ready  <= 1'b0;
                    r_ctrl_code <= CODE_STOP;
                end
            endcase
        end
    end

    assign LpA       = r_abc[2];
    assign LpB       = r_abc[1];
    assign LpC       = r_abc[0];
    assign LpOe      = r_lp_oe;
    assign HsEn      = r_hs_en;
    assign TxReadyHS = r_tx_ready;
    assign LpDone    = r_lp_done;
    assign CtrlCode  = r_ctrl_code;

endmodule

// File: tb/tb_tx_ctrl_sequencer.sv
// Bench for tx_ctrl_sequencer: directed scenarios plus randomized requests checked
// against a phase/elapsed-time reference model.
`timescale 1ns/1ps
module tb_tx_ctrl_sequencer;

    localparam int T_HS_RQST  = 3;
    localparam int T_BRIDGE   = 5;
    localparam int T_TRAIL    = 4;
    localparam int T_LP_RQST  = 3;
    localparam int T_STOP_MIN = 2;
    localparam int N_RAND     = 3000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       HsReq = 1'b0;
    logic       LpReq = 1'b0;
    logic       LpA, LpB, LpC, LpOe, HsEn, TxReadyHS, LpDone;
    logic [1:0] CtrlCode;

    int n_vec = 0;
    int n_err = 0;

    tx_ctrl_sequencer #(
        .T_HS_RQST (T_HS_RQST),
        .T_BRIDGE  (T_BRIDGE),
        .T_TRAIL   (T_TRAIL),
        .T_LP_RQST (T_LP_RQST),
        .T_STOP_MIN(T_STOP_MIN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .HsReq    (HsReq),
        .LpReq    (LpReq),
        .LpA      (LpA),
        .LpB      (LpB),
        .LpC      (LpC),
        .LpOe     (LpOe),
        .HsEn     (HsEn),
        .TxReadyHS(TxReadyHS),
        .LpDone   (LpDone),
        .CtrlCode (CtrlCode)
    );

    always #5 clk = ~clk;

    // {A,B,C, LpOe, HsEn, TxReadyHS, LpDone, CtrlCode[1:0]}
    logic [8:0] obs;
    assign obs = {LpA, LpB, LpC, LpOe, HsEn, TxReadyHS, LpDone, CtrlCode};

    localparam logic [8:0] E_STOP = 9'b111_1_0_0_0_00;
    localparam logic [8:0] E_DONE = 9'b111_1_0_0_1_00;
    localparam logic [8:0] E_HSRQ = 9'b001_1_0_0_0_01;
    localparam logic [8:0] E_BRDG = 9'b000_1_0_0_0_10;
    localparam logic [8:0] E_ACT  = 9'b000_0_1_1_0_00;
    localparam logic [8:0] E_TRL  = 9'b000_0_1_0_0_00;
    localparam logic [8:0] E_LPRQ = 9'b100_1_0_0_0_11;
    localparam logic [8:0] M_ALL  = 9'b111_111111;
    localparam logic [8:0] M_TRL  = 9'b000_111111;   // line levels undriven during trail

    typedef enum {P_STOP, P_HS_REQUEST, P_BRIDGE, P_HS_BURST, P_TRAIL, P_LP_REQUEST} phase_t;
    phase_t m_phase;
    int     m_len;    // cycles already spent in the current phase, counting this one
    int     m_need;   // cycles of Stop required before a request is honoured
    logic   m_done;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_advance(input logic hs, input logic lp, input logic rs);
        if (!rs) begin
            m_phase = P_STOP; m_len = 1; m_need = 1; m_done = 1'b0;
            return;
        end
        m_done = 1'b0;
        case (m_phase)
            P_STOP:
                if (m_len >= m_need && hs)      begin m_phase = P_HS_REQUEST; m_len = 1; end
                else if (m_len >= m_need && lp) begin m_phase = P_LP_REQUEST; m_len = 1; end
                else m_len++;
            P_HS_REQUEST:
                if (!hs)                        begin m_phase = P_STOP; m_len = 1; m_need = T_STOP_MIN; end
                else if (m_len == T_HS_RQST)    begin m_phase = P_BRIDGE; m_len = 1; end
                else m_len++;
            P_BRIDGE:
                if (!hs)                        begin m_phase = P_STOP; m_len = 1; m_need = T_STOP_MIN; end
                else if (m_len == T_BRIDGE)     begin m_phase = P_HS_BURST; m_len = 1; end
                else m_len++;
            P_HS_BURST:
                if (!hs)                        begin m_phase = P_TRAIL; m_len = 1; end
                else m_len++;
            P_TRAIL:
                if (m_len == T_TRAIL)           begin m_phase = P_STOP; m_len = 1; m_need = T_STOP_MIN; end
                else m_len++;
            P_LP_REQUEST:
                if (!lp)                        begin m_phase = P_STOP; m_len = 1; m_need = T_STOP_MIN; end
                else if (m_len == T_LP_RQST)    begin m_phase = P_STOP; m_len = 1; m_need = T_STOP_MIN; m_done = 1'b1; end
                else m_len++;
            default: m_phase = P_STOP;
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0; HsReq = 1'b0; LpReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); n_vec++;
            if (obs !== E_STOP) begin n_err++; $display("FAIL reset_hold cyc%0d: got %b want %b", i, obs, E_STOP); end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(); n_vec++;
            if (obs !== E_STOP) begin n_err++; $display("FAIL reset_idle cyc%0d: got %b want %b", i, obs, E_STOP); end
        end
    endtask

    task automatic test_hs_entry_exit();
        HsReq = 1'b1;
        for (int i = 0; i < T_HS_RQST; i++) begin
            step(); n_vec++;
            if (obs !== E_HSRQ) begin n_err++; $display("FAIL hs_rqst cyc%0d: got %b want %b", i, obs, E_HSRQ); end
        end
        for (int i = 0; i < T_BRIDGE; i++) begin
            step(); n_vec++;
            if (obs !== E_BRDG) begin n_err++; $display("FAIL hs_bridge cyc%0d: got %b want %b", i, obs, E_BRDG); end
        end
        for (int i = 0; i < 3; i++) begin
            step(); n_vec++;
            if (obs !== E_ACT) begin n_err++; $display("FAIL hs_active cyc%0d: got %b want %b", i, obs, E_ACT); end
        end
        HsReq = 1'b0;
        for (int i = 0; i < T_TRAIL; i++) begin
            step(); n_vec++;
            if ((obs & M_TRL) !== E_TRL) begin n_err++; $display("FAIL hs_trail cyc%0d: got %b want %b", i, obs & M_TRL, E_TRL); end
        end
        for (int i = 0; i < 2; i++) begin
            step(); n_vec++;
            if (obs !== E_STOP) begin n_err++; $display("FAIL hs_exit_stop cyc%0d: got %b want %b", i, obs, E_STOP); end
        end
    endtask

    task automatic test_lp_request();
        step(); n_vec++;
        if (obs !== E_STOP) begin n_err++; $display("FAIL lp_pre_stop: got %b want %b", obs, E_STOP); end
        LpReq = 1'b1;
        for (int i = 0; i < T_LP_RQST; i++) begin
            step(); n_vec++;
            if (obs !== E_LPRQ) begin n_err++; $display("FAIL lp_rqst cyc%0d: got %b want %b", i, obs, E_LPRQ); end
        end
        step(); n_vec++;
        if (obs !== E_DONE) begin n_err++; $display("FAIL lp_done_pulse: got %b want %b", obs, E_DONE); end
        LpReq = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(); n_vec++;
            if (obs !== E_STOP) begin n_err++; $display("FAIL lp_done_width cyc%0d: got %b want %b", i, obs, E_STOP); end
        end
    endtask

    task automatic test_priority_abort();
        HsReq = 1'b1; LpReq = 1'b1;
        for (int i = 0; i < T_HS_RQST; i++) begin
            step(); n_vec++;
            if (obs !== E_HSRQ) begin n_err++; $display("FAIL prio_hs_rqst cyc%0d: got %b want %b", i, obs, E_HSRQ); end
        end
        for (int i = 0; i < 2; i++) begin
            step(); n_vec++;
            if (obs !== E_BRDG) begin n_err++; $display("FAIL prio_bridge cyc%0d: got %b want %b", i, obs, E_BRDG); end
        end
        HsReq = 1'b0;
        for (int i = 0; i < T_STOP_MIN; i++) begin
            step(); n_vec++;
            if (obs !== E_STOP) begin n_err++; $display("FAIL abort_stop cyc%0d: got %b want %b", i, obs, E_STOP); end
        end
        for (int i = 0; i < T_LP_RQST; i++) begin
            step(); n_vec++;
            if (obs !== E_LPRQ) begin n_err++; $display("FAIL lp_after_dwell cyc%0d: got %b want %b", i, obs, E_LPRQ); end
        end
        step(); n_vec++;
        if (obs !== E_DONE) begin n_err++; $display("FAIL lp_after_dwell_done: got %b want %b", obs, E_DONE); end
        LpReq = 1'b0;
        step(); n_vec++;
        if (obs !== E_STOP) begin n_err++; $display("FAIL prio_final_stop: got %b want %b", obs, E_STOP); end
    endtask

    task automatic test_reset_mid_hs();
        HsReq = 1'b1;
        for (int i = 0; i < T_HS_RQST + T_BRIDGE; i++) step();
        step(); n_vec++;
        if (obs !== E_ACT) begin n_err++; $display("FAIL mid_active: got %b want %b", obs, E_ACT); end
        rst_n = 1'b0;
        step(); n_vec++;
        if (obs !== E_STOP) begin n_err++; $display("FAIL mid_reset: got %b want %b", obs, E_STOP); end
        rst_n = 1'b1; HsReq = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(); n_vec++;
            if (obs !== E_STOP) begin n_err++; $display("FAIL mid_no_trail cyc%0d: got %b want %b", i, obs, E_STOP); end
        end
    endtask

    task automatic test_stop_dwell();
        HsReq = 1'b1;
        for (int i = 0; i < T_HS_RQST + T_BRIDGE; i++) step();
        step(); n_vec++;
        if (obs !== E_ACT) begin n_err++; $display("FAIL dwell_active: got %b want %b", obs, E_ACT); end
        HsReq = 1'b0;
        for (int i = 0; i < T_TRAIL; i++) begin
            step(); n_vec++;
            if ((obs & M_TRL) !== E_TRL) begin n_err++; $display("FAIL dwell_trail cyc%0d: got %b want %b", i, obs & M_TRL, E_TRL); end
        end
        step(); n_vec++;
        if (obs !== E_STOP) begin n_err++; $display("FAIL dwell_first_stop: got %b want %b", obs, E_STOP); end
        HsReq = 1'b1;
        for (int i = 1; i < T_STOP_MIN; i++) begin
            step(); n_vec++;
            if (obs !== E_STOP) begin n_err++; $display("FAIL dwell_hold cyc%0d: got %b want %b", i, obs, E_STOP); end
        end
        step(); n_vec++;
        if (obs !== E_HSRQ) begin n_err++; $display("FAIL dwell_release: got %b want %b", obs, E_HSRQ); end
        HsReq = 1'b0;
        step(); n_vec++;
        if (obs !== E_STOP) begin n_err++; $display("FAIL rqst_abort: got %b want %b", obs, E_STOP); end
    endtask

    task automatic test_random();
        logic       hs, lp, rs;
        logic [8:0] exp_v, msk;
        rst_n = 1'b0; HsReq = 1'b0; LpReq = 1'b0;
        step();
        m_phase = P_STOP; m_len = 1; m_need = 1; m_done = 1'b0;
        hs = 1'b0; lp = 1'b0;
        for (int c = 0; c < N_RAND; c++) begin
            msk = M_ALL;
            case (m_phase)
                P_STOP:       exp_v = m_done ? E_DONE : E_STOP;
                P_HS_REQUEST: exp_v = E_HSRQ;
                P_BRIDGE:     exp_v = E_BRDG;
                P_HS_BURST:   exp_v = E_ACT;
                P_TRAIL:      begin exp_v = E_TRL; msk = M_TRL; end
                default:      exp_v = E_LPRQ;
            endcase
            n_vec++;
            if ((obs & msk) !== (exp_v & msk)) begin
                n_err++;
                $display("FAIL random cyc%0d phase %s: got %b want %b", c, m_phase.name(), obs & msk, exp_v & msk);
            end
            if ($urandom_range(0, 15) == 0) hs = ~hs;
            if ($urandom_range(0, 11) == 0) lp = ~lp;
            rs = ($urandom_range(0, 399) != 0);
            HsReq = hs; LpReq = lp; rst_n = rs;
            model_advance(hs, lp, rs);
            step();
        end
        rst_n = 1'b1; HsReq = 1'b0; LpReq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hs_entry_exit();
        test_lp_request();
        test_priority_abort();
        test_reset_mid_hs();
        test_stop_dwell();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
